hdlc_rx_deframer: RTL and testbench
===================================

// Module: hdlc_rx_deframer
// PURPOSE
//  Bit-level HDLC receive front end. Samples the serial Rx line and detects flags (0x7E) and aborts.
//  Removes stuffed zeros and assembles LSB-first data bytes.
//  Drives the frame-status signals (Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame) consumed by the
//  Rx control/buffer stage and checked by the Rx assertion module.
// PARAMETERS
//  MAX_BYTES  128  max data bytes per frame (incl. FCS); byte MAX_BYTES+1 raises Rx_Overflow
// PORTS
//  Clk             in   1  system clock; all logic on posedge
//  Rst             in   1  synchronous reset, active-high
//  RxEN            in   1  bit enable; 0 = freeze all state, strobes forced 0
//  Rx              in   1  serial receive line, one bit per enabled cycle, LSB first
//  Rx_FlagDetect   out  1  1-cycle pulse: flag 0111_1110 received
//  Rx_AbortDetect  out  1  1-cycle pulse: abort (0 followed by 7 ones) received
//  Rx_ValidFrame   out  1  level: inside a frame (between opening and closing flag)
//  Rx_Data         out  8  assembled data byte, valid while Rx_NewByte=1
//  Rx_NewByte      out  1  1-cycle strobe: Rx_Data holds a new byte
//  Rx_EoF          out  1  1-cycle pulse: frame closed by flag
//  Rx_FrameError   out  1  1-cycle pulse with Rx_EoF: residual bit count != 0 at closing flag
//  Rx_Overflow     out  1  level: byte count exceeded MAX_BYTES; cleared at next flag or abort
// BEHAVIOUR
//  Reset: all outputs 0, shift reg 8'h00, ones counter 0, state IDLE.
//  Shift reg sr[7:0]: on each enabled edge sr <= {Rx, sr[7:1]} (newest bit in sr[7]).
//  Flag: sr==8'h7E is registered into Rx_FlagDetect.
//   - If the edge sampling the final 0 is edge t, Rx_FlagDetect is high in the cycle after edge t+1.
//   - It is therefore sampled high at edge t+2.
//  Abort: sr==8'hFE produces the same timing on Rx_AbortDetect.
//   - Fires once per run of ones. A continued idle run (all ones) gives no further pulses.
//  Data path: the bit leaving sr[0] feeds the destuffer. This is a fixed 8-bit delay, so flag bits are
//   known before they reach data.
//   - The 8 delayed bits belonging to a detected flag or abort are discarded.
//  Destuff: count consecutive delayed ones. A 0 following exactly 5 ones is dropped (not assembled);
//   the counter clears on any 0.
//  Byte assembly: 3-bit bit counter.
//   - When the 8th kept bit enters, Rx_Data is updated and Rx_NewByte pulses next cycle. The counter
//     wraps to 0.
//   - Bytes are emitted only in state FRAME.
//  FSM:
//   - IDLE  --flag-->  HUNT  (Rx_FlagDetect pulse)
//   - HUNT  --flag-->  HUNT  (back-to-back/shared flags; no EoF)
//   - HUNT  --first kept data bit-->  FRAME  (Rx_ValidFrame=1 from next cycle)
//   - FRAME --flag-->  HUNT
//       Rx_EoF pulses with Rx_FlagDetect. Rx_ValidFrame falls in the same cycle.
//       Rx_FrameError=1 iff bit counter != 0. The partial byte is discarded.
//   - FRAME --abort-->  IDLE
//       Rx_ValidFrame stays 1 during the Rx_AbortDetect cycle and falls the cycle after.
//       No Rx_EoF. The partial byte is discarded.
//   - any state, 15+ consecutive raw ones  -->  IDLE (line idle)
//  Abort outside FRAME: Rx_AbortDetect still pulses; no state change beyond the idle rule.
//  Overflow: byte count (0..MAX_BYTES+1, saturating) resets at each flag.
//   - On byte MAX_BYTES+1, Rx_Overflow goes 1 and no further Rx_NewByte pulses occur in that frame.
//   - Rx_ValidFrame is unaffected.
//  Simultaneous: flag and abort patterns are mutually exclusive. Rx_NewByte never coincides with
//   Rx_EoF (the closing-flag bits are discarded).
//  RxEN=0: sr, counters and state hold; pulse outputs 0; levels hold.
//  Rst mid-frame: immediate return to reset state on the next edge; no Rx_EoF.
// STRUCTURE
//  hdlc_pkg: FLAG_PAT=8'h7E, ABORT_PAT=8'hFE, IDLE_ONES=15, typedef enum {IDLE,HUNT,FRAME} rx_state_t.
//  Sub-module hdlc_rx_destuff: ones counter, zero drop, bit counter and byte assembly. Outputs a kept
//   bit plus a byte-done strobe.
//  Top: sr, pattern compare, flag/abort discard counter, FSM, byte/overflow counters.
// TESTING
//  1. Rx=1 idle, then flag 0111_1110 at edge t
//     -> Rx_FlagDetect=1 sampled at edge t+2 only; Rx_ValidFrame stays 0.
//  2. flag, bytes 0x55 0xA5, flag -> Rx_NewByte x2 with Rx_Data=0x55 then 0xA5; Rx_EoF=1,
//     Rx_FrameError=0; Rx_ValidFrame 0 after EoF.
//  3. flag, byte 0xFF (sent 1111_1011_1), flag -> single byte 0xFF (stuffed 0 removed), no FrameError.
//  4. flag, 0x12, 4 extra bits, flag -> one byte 0x12, Rx_EoF with Rx_FrameError=1.
//  5. flag, 0x34, then 0 + 7 ones -> Rx_AbortDetect pulse with Rx_ValidFrame=1, Rx_ValidFrame=0 next
//     cycle, no Rx_EoF.
//  6. MAX_BYTES=4, frame of 6 bytes -> 4 Rx_NewByte, Rx_Overflow=1 on byte 5, cleared by next flag.

Source files
------------

// File: rtl/hdlc_pkg.sv
// HDLC receive deframer shared definitions:
// line patterns, idle threshold, stuffing run length and receiver state.
package hdlc_pkg;
   localparam logic [7:0]  FLAG_PAT   = 8'h7E;
   localparam logic [7:0]  ABORT_PAT  = 8'hFE;
   localparam int unsigned IDLE_ONES  = 15;
   localparam int unsigned STUFF_ONES = 5;
   typedef enum logic [1:0] {IDLE, HUNT, FRAME} rx_state_t;
endpackage

// File: rtl/hdlc_rx_destuff.sv
// Zero destuffer and LSB-first byte assembler for the delayed data bits.
// Emits a kept-bit flag and a byte-done strobe with the completed byte.
module hdlc_rx_destuff
   import hdlc_pkg::*;
(
   input  logic       Clk,
   input  logic       Rst,
   input  logic       bit_en_i,
   input  logic       clr_i,
   input  logic       bit_i,
   output logic       kept_o,
   output logic       done_o,
   output logic [7:0] byte_o,
   output logic [2:0] bitcnt_o
);
   logic [2:0] ones_q, ones_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] acc_q, acc_d;
   logic       drop;

   assign drop     = bit_en_i && !bit_i && (ones_q == 3'(STUFF_ONES));
   assign kept_o   = bit_en_i && !drop;
   assign done_o   = kept_o && (cnt_q == 3'd7);
   assign byte_o   = {bit_i, acc_q[7:1]};
   assign bitcnt_o = cnt_q;

   always_comb begin
      ones_d = ones_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      if (clr_i) begin
         ones_d = '0;
         cnt_d  = '0;
         acc_d  = '0;
      end else if (bit_en_i) begin
         // saturate so a long run of ones never aliases back to five
         if (!bit_i)
            ones_d = '0;
         else if (ones_q != 3'd7)
            ones_d = ones_q + 3'd1;
         if (kept_o) begin
            acc_d = byte_o;
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         ones_q <= '0;
         cnt_q  <= '0;
         acc_q  <= '0;
      end else begin
         ones_q <= ones_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
      end
   end
endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC bit-level receive front end: flag/abort detection, zero
// destuffing via hdlc_rx_destuff, frame state and byte/overflow counting.
module hdlc_rx_deframer
   import hdlc_pkg::*;
#(
   parameter int unsigned MAX_BYTES = 128
)(
   input  logic       Clk,
   input  logic       Rst,
   input  logic       RxEN,
   input  logic       Rx,
   output logic       Rx_FlagDetect,
   output logic       Rx_AbortDetect,
   output logic       Rx_ValidFrame,
   output logic [7:0] Rx_Data,
   output logic       Rx_NewByte,
   output logic       Rx_EoF,
   output logic       Rx_FrameError,
   output logic       Rx_Overflow
);
   localparam int CW = $clog2(MAX_BYTES + 2);
   localparam logic [CW-1:0] BMAX = CW'(MAX_BYTES);
   localparam logic [CW-1:0] BSAT = CW'(MAX_BYTES + 1);

   logic [7:0]    sr_q;
   logic [2:0]    disc_q;
   logic [3:0]    ones_q;
   logic [CW-1:0] bcnt_q;
   rx_state_t     state_q;

   logic       flag_hit, abort_hit, idle_hit, discard;
   logic       kept, done;
   logic [7:0] dbyte;
   logic [2:0] bitcnt;

   assign flag_hit  = (sr_q == FLAG_PAT);
   assign abort_hit = (sr_q == ABORT_PAT);
   assign idle_hit  = Rx && (ones_q >= 4'(IDLE_ONES - 1));
   // the bit leaving sr belongs to a pattern still inside the window
   assign discard   = flag_hit || abort_hit || (disc_q != 3'd0);

   hdlc_rx_destuff u_destuff (
      .Clk      (Clk),
      .Rst      (Rst),
      .bit_en_i (RxEN && !discard),
      .clr_i    (RxEN && (flag_hit || abort_hit)),
      .bit_i    (sr_q[0]),
      .kept_o   (kept),
      .done_o   (done),
      .byte_o   (dbyte),
      .bitcnt_o (bitcnt)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         sr_q           <= '0;
         disc_q         <= '0;
         ones_q         <= '0;
         bcnt_q         <= '0;
         state_q        <= IDLE;
         Rx_FlagDetect  <= 1'b0;
         Rx_AbortDetect <= 1'b0;
         Rx_ValidFrame  <= 1'b0;
         Rx_Data        <= '0;
         Rx_NewByte     <= 1'b0;
         Rx_EoF         <= 1'b0;
         Rx_FrameError  <= 1'b0;
         Rx_Overflow    <= 1'b0;
      end else if (!RxEN) begin
         Rx_FlagDetect  <= 1'b0;
         Rx_AbortDetect <= 1'b0;
         Rx_NewByte     <= 1'b0;
         Rx_EoF         <= 1'b0;
         Rx_FrameError  <= 1'b0;
      end else begin
         sr_q           <= {Rx, sr_q[7:1]};
         Rx_FlagDetect  <= flag_hit;
         Rx_AbortDetect <= abort_hit;
         Rx_NewByte     <= 1'b0;
         Rx_EoF         <= 1'b0;
         Rx_FrameError  <= 1'b0;
         Rx_ValidFrame  <= (state_q == FRAME);
         if (!Rx)
            ones_q <= '0;
         else if (ones_q != 4'(IDLE_ONES))
            ones_q <= ones_q + 4'd1;
         if (flag_hit || abort_hit)
            disc_q <= 3'd7;
         else if (disc_q != 3'd0)
            disc_q <= disc_q - 3'd1;

         if (flag_hit) begin
            state_q       <= HUNT;
            bcnt_q        <= '0;
            Rx_Overflow   <= 1'b0;
            Rx_ValidFrame <= 1'b0;
            if (state_q == FRAME) begin
               Rx_EoF        <= 1'b1;
               Rx_FrameError <= (bitcnt != 3'd0);
            end
         end else if (abort_hit) begin
            bcnt_q      <= '0;
            Rx_Overflow <= 1'b0;
            if (state_q == FRAME)
               state_q <= IDLE;
         end else if (idle_hit) begin
            state_q <= IDLE;
         end else if (done && state_q == FRAME) begin
            if (bcnt_q != BSAT)
               bcnt_q <= bcnt_q + 1'b1;
            if (bcnt_q < BMAX && !Rx_Overflow) begin
               Rx_NewByte <= 1'b1;
               Rx_Data    <= dbyte;
            end else if (bcnt_q == BMAX) begin
               Rx_Overflow <= 1'b1;
            end
         end else if (kept && state_q == HUNT) begin
            state_q       <= FRAME;
            Rx_ValidFrame <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Randomized and directed bench for hdlc_rx_deframer against a
// frame-level encoder model with expected byte/frame event queues.
module tb_hdlc_rx_deframer;
   localparam int MAXB = 4;

   logic       Clk = 1'b0;
   logic       Rst, RxEN, Rx;
   logic       Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame;
   logic [7:0] Rx_Data;
   logic       Rx_NewByte, Rx_EoF, Rx_FrameError, Rx_Overflow;

   always #5 Clk = ~Clk;

   hdlc_rx_deframer #(.MAX_BYTES(MAXB)) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .RxEN           (RxEN),
      .Rx             (Rx),
      .Rx_FlagDetect  (Rx_FlagDetect),
      .Rx_AbortDetect (Rx_AbortDetect),
      .Rx_ValidFrame  (Rx_ValidFrame),
      .Rx_Data        (Rx_Data),
      .Rx_NewByte     (Rx_NewByte),
      .Rx_EoF         (Rx_EoF),
      .Rx_FrameError  (Rx_FrameError),
      .Rx_Overflow    (Rx_Overflow)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // expected side: bit stream to send plus event queues
   bit         tx_q[$];
   logic [7:0] frame_q[$];
   logic [7:0] exp_bytes[$];
   bit         exp_err[$], exp_ovf[$];
   int         exp_flags, exp_aborts;

   // observed side, filled by the monitor
   logic [7:0] obs_bytes[$];
   bit         obs_err[$], obs_ovf[$], obs_vf[$], obs_fl[$];
   int         obs_flags, obs_aborts, stray;
   bit         ovf_seen;

   always @(negedge Clk) begin
      if (!Rst) begin
         if (Rx_FlagDetect)  obs_flags++;
         if (Rx_AbortDetect) begin
            obs_aborts++;
            ovf_seen = 1'b0;
         end
         if (Rx_NewByte) obs_bytes.push_back(Rx_Data);
         if (Rx_Overflow) ovf_seen = 1'b1;
         if (Rx_EoF) begin
            obs_err.push_back(Rx_FrameError);
            obs_ovf.push_back(ovf_seen);
            obs_vf.push_back(Rx_ValidFrame);
            obs_fl.push_back(Rx_FlagDetect);
            ovf_seen = 1'b0;
         end
         if ((Rx_NewByte && Rx_EoF) || (Rx_FrameError && !Rx_EoF) ||
             (Rx_FlagDetect && Rx_AbortDetect))
            stray++;
      end
   end

   task automatic tick(input logic b, input logic en);
      Rx   = b;
      RxEN = en;
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_all();
      tx_q.delete(); exp_bytes.delete(); exp_err.delete(); exp_ovf.delete();
      obs_bytes.delete(); obs_err.delete(); obs_ovf.delete();
      obs_vf.delete(); obs_fl.delete();
      exp_flags = 0; exp_aborts = 0;
      obs_flags = 0; obs_aborts = 0; stray = 0; ovf_seen = 1'b0;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      check("reset_outs",
            {Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_Data,
             Rx_NewByte, Rx_EoF, Rx_FrameError, Rx_Overflow}, 0);
      clear_all();
      Rst = 1'b0;
   endtask

   // a run of idle ones after a zero is one abort pattern
   task automatic add_idle(input int n);
      repeat (n) tx_q.push_back(1'b1);
      if (n >= 7) exp_aborts++;
   endtask

   task automatic add_flag();
      logic [7:0] fb = 8'h7E;
      for (int i = 0; i < 8; i++) tx_q.push_back(fb[i]);
      exp_flags++;
   endtask

   task automatic add_raw_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
   endtask

   // frame from frame_q plus k trailing bits, bit-stuffed, flag delimited
   task automatic add_frame(input int k);
      bit raw[$];
      int run = 0;
      add_flag();
      foreach (frame_q[i])
         for (int b = 0; b < 8; b++) raw.push_back(frame_q[i][b]);
      repeat (k) raw.push_back(1'($urandom_range(0, 1)));
      foreach (raw[i]) begin
         tx_q.push_back(raw[i]);
         run = raw[i] ? run + 1 : 0;
         if (run == 5) begin
            tx_q.push_back(1'b0);
            run = 0;
         end
      end
      add_flag();
      foreach (frame_q[i])
         if (i < MAXB) exp_bytes.push_back(frame_q[i]);
      exp_err.push_back(k != 0);
      exp_ovf.push_back(frame_q.size() > MAXB);
   endtask

   task automatic send(input bit gaps);
      while (tx_q.size() > 0) begin
         if (gaps && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) tick(1'($urandom_range(0, 1)), 1'b0);
         tick(tx_q.pop_front(), 1'b1);
      end
   endtask

   task automatic compare(input string tag);
      check({tag, ".nbytes"}, obs_bytes.size(), exp_bytes.size());
      for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++)
         check({tag, ".byte"}, obs_bytes[i], exp_bytes[i]);
      check({tag, ".neof"}, obs_err.size(), exp_err.size());
      for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++) begin
         check({tag, ".ferr"}, obs_err[i], exp_err[i]);
         check({tag, ".ovf"}, obs_ovf[i], exp_ovf[i]);
         check({tag, ".vf_at_eof"}, obs_vf[i], 0);
         check({tag, ".flag_at_eof"}, obs_fl[i], 1);
      end
      check({tag, ".flags"}, obs_flags, exp_flags);
      check({tag, ".aborts"}, obs_aborts, exp_aborts);
      check({tag, ".stray"}, stray, 0);
   endtask

   function automatic logic [7:0] pick_byte();
      case ($urandom_range(0, 7))
         0: return 8'hFF;
         1: return 8'h7E;
         2: return 8'hFE;
         3: return 8'h3F;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      Rst = 1'b1; RxEN = 1'b0; Rx = 1'b1;

      // flag detect timing, line idle around it
      do_reset();
      add_idle(16);
      send(1'b0);
      for (int i = 0; i < 7; i++) tick(i != 0, 1'b1);
      tick(1'b0, 1'b1);
      check("t1_before", Rx_FlagDetect, 0);
      tick(1'b1, 1'b1);
      check("t1_flag", Rx_FlagDetect, 1);
      check("t1_vf", Rx_ValidFrame, 0);
      tick(1'b1, 1'b1);
      check("t1_after", Rx_FlagDetect, 0);
      exp_flags = 1;
      add_idle(14);
      send(1'b0);
      check("t1_vf_end", Rx_ValidFrame, 0);
      compare("t1");

      // two clean bytes
      do_reset();
      add_idle(16);
      frame_q = '{8'h55, 8'hA5};
      add_frame(0);
      add_idle(16);
      send(1'b0);
      compare("t2");

      // stuffed 0xFF
      do_reset();
      add_idle(16);
      frame_q = '{8'hFF};
      add_frame(0);
      add_idle(16);
      send(1'b0);
      compare("t3");

      // residual bits give frame error
      do_reset();
      add_idle(16);
      frame_q = '{8'h12};
      add_frame(4);
      add_idle(16);
      send(1'b0);
      compare("t4");

      // abort inside a frame
      do_reset();
      add_idle(16);
      add_flag();
      add_raw_byte(8'h34);
      exp_bytes.push_back(8'h34);
      send(1'b0);
      tick(1'b0, 1'b1);
      repeat (6) tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      check("t5_before", Rx_AbortDetect, 0);
      tick(1'b1, 1'b1);
      check("t5_abort", Rx_AbortDetect, 1);
      check("t5_vf_hold", Rx_ValidFrame, 1);
      tick(1'b1, 1'b1);
      check("t5_abort_end", Rx_AbortDetect, 0);
      check("t5_vf_fall", Rx_ValidFrame, 0);
      exp_aborts++;
      repeat (14) tick(1'b1, 1'b1);
      compare("t5");

      // overflow beyond MAXB bytes
      do_reset();
      add_idle(16);
      frame_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      add_frame(0);
      add_idle(16);
      send(1'b0);
      check("t6_ovf_clr", Rx_Overflow, 0);
      compare("t6");

      // reset in the middle of a frame
      do_reset();
      add_idle(16);
      add_flag();
      add_raw_byte(8'hA7);
      repeat (4) tx_q.push_back(1'b0);
      send(1'b0);
      do_reset();
      add_idle(16);
      frame_q = '{8'hC3};
      add_frame(0);
      add_idle(16);
      send(1'b1);
      compare("rstmid");

      // randomized frames with enable gaps
      do_reset();
      add_idle(16);
      for (int f = 0; f < 24; f++) begin
         int n, k;
         n = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 6) : $urandom_range(1, 4);
         k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
         frame_q.delete();
         repeat (n) frame_q.push_back(pick_byte());
         add_frame(k);
         if ($urandom_range(0, 1) == 1) add_idle($urandom_range(15, 20));
      end
      add_idle(16);
      send(1'b1);
      compare("rand");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
